// File: rtl/prbs31_checker_if.sv
// Bundles the PRBS31 checker data input, controls and status outputs.
// The master side drives the serial stream. The slave side is the checker.
interface prbs31_checker_if #(
    parameter int CNT_W = 16
);
    logic             din;
    logic             din_valid;
    logic             clear_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic             lol_sticky;
    logic [1:0]       state;

    modport master (
        output din, din_valid, clear_cnt,
        input  locked, err_pulse, err_count, lol_sticky, state
    );

    modport slave (
        input  din, din_valid, clear_cnt,
        output locked, err_pulse, err_count, lol_sticky, state
    );
endinterface

// File: rtl/prbs31_checker.sv
// Serial PRBS31 (x^31 + x^28 + 1) checker.
// HUNT fills the reference register. SYNC self-synchronises until LOCK_MATCHES
// consecutive bits are predicted correctly. LOCKED free-runs the reference
// and counts bit errors, and a dense burst of errors inside one observation
// window drops the checker back to HUNT.
module prbs31_checker #(
    parameter int LOCK_MATCHES = 64,
    parameter int WIN_LEN      = 1024,
    parameter int ERR_LIMIT    = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,   // asynchronous, active-high
    prbs31_checker_if.slave  bus
);

    localparam int MC_W = $clog2(LOCK_MATCHES + 1);
    localparam int WC_W = $clog2(WIN_LEN);
    localparam int WE_W = $clog2(ERR_LIMIT + 1);

    localparam logic [4:0]      FILL_LAST = 5'd30;
    localparam logic [MC_W-1:0] MATCH_TGT = MC_W'(LOCK_MATCHES);
    localparam logic [WC_W-1:0] WIN_LAST  = WC_W'(WIN_LEN - 1);
    localparam logic [WE_W-1:0] ERR_LIM   = WE_W'(ERR_LIMIT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e           state_q,     state_d;
    logic [30:0]      sr_q,        sr_d;
    logic [4:0]       fill_q,      fill_d;
    logic [MC_W-1:0]  match_q,     match_d;
    logic [WC_W-1:0]  win_cnt_q,   win_cnt_d;
    logic [WE_W-1:0]  win_err_q,   win_err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             err_pulse_q, err_pulse_d;
    logic             lol_q,       lol_d;

    logic             pred;
    logic             mis;
    logic             e_locked;
    logic             lol_event;
    logic [WE_W-1:0]  win_err_sum;

    // Reference prediction from the recurrence b[n] = b[n-28] ^ b[n-31].
    assign pred = sr_q[27] ^ sr_q[30];
    assign mis  = bus.din ^ pred;

    // Next-state, data path, window and error accounting.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_count_d = err_count_q;
        lol_d       = lol_q;
        e_locked    = 1'b0;
        lol_event   = 1'b0;
        win_err_sum = '0;

        if (bus.din_valid) begin
            unique case (state_q)
                HUNT: begin
                    sr_d = {sr_q[29:0], bus.din};
                    if (fill_q == FILL_LAST) begin
                        state_d = SYNC;
                        fill_d  = '0;
                    end else begin
                        fill_d  = fill_q + 5'd1;
                    end
                end

                SYNC: begin
                    sr_d = {sr_q[29:0], bus.din};
                    // An all-zero register predicts zeros forever, so it may never build a lock.
                    if (sr_q == '0 || mis) begin
                        match_d = '0;
                    end else begin
                        match_d = match_q + MC_W'(1);
                    end
                    if (match_d == MATCH_TGT) begin
                        state_d   = LOCKED;
                        match_d   = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end
                end

                LOCKED: begin
                    // The reference free-runs on its own prediction, so a flipped bit costs one error.
                    sr_d        = {sr_q[29:0], pred};
                    e_locked    = mis;
                    win_err_sum = win_err_q + WE_W'(mis);
                    if (win_err_sum >= ERR_LIM) begin
                        lol_event = 1'b1;
                        state_d   = HUNT;
                        sr_d      = '0;
                        fill_d    = '0;
                        match_d   = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WC_W'(1);
                        win_err_d = win_err_sum;
                    end
                end

                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        err_pulse_d = e_locked;
        if (e_locked && err_count_q != '1) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
        if (lol_event) begin
            lol_d = 1'b1;
        end

        // A clear keeps an error or a loss of lock that lands on the same edge.
        if (bus.clear_cnt) begin
            err_count_d = e_locked ? CNT_W'(1) : '0;
            lol_d       = lol_event;
        end
    end

    // State and counter registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
            lol_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_pulse_d;
            lol_q       <= lol_d;
        end
    end

    assign bus.locked     = (state_q == LOCKED);
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_count  = err_count_q;
    assign bus.lol_sticky = lol_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker, driven by a seed-1 PRBS31 generator model.
module tb_prbs31_checker;

    logic clk;
    logic rst_n;

    prbs31_checker_if #(.CNT_W(16)) bus ();

    prbs31_checker #(
        .LOCK_MATCHES(64),
        .WIN_LEN     (1024),
        .ERR_LIMIT   (16),
        .CNT_W       (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int          checks;
    int          errors;
    int          vidx;        // valid bits since reset, 1-based after each step
    int          pulses;      // err_pulse cycles seen since reset
    bit          saw_locked;
    bit          zero_mode;
    logic [30:0] lfsr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Generator: Fibonacci LFSR emitting lfsr[30], feedback lfsr[30]^lfsr[27].
    function automatic logic gen_bit();
        logic b;
        b    = lfsr[30];
        lfsr = {lfsr[29:0], lfsr[30] ^ lfsr[27]};
        return b;
    endfunction

    task automatic do_reset();
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.clear_cnt = 1'b0;
        rst_n         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b0;
        lfsr       = 31'd1;
        vidx       = 0;
        pulses     = 0;
        saw_locked = 1'b0;
        zero_mode  = 1'b0;
    endtask

    // One clock: drive inputs, take the edge, sample outputs 1 time unit later.
    task automatic step(input bit valid, input bit flip, input bit clr);
        logic g;
        if (valid) begin
            g       = zero_mode ? 1'b0 : gen_bit();
            bus.din = g ^ flip;
        end else begin
            bus.din = 1'($urandom_range(0, 1));
        end
        bus.din_valid = valid;
        bus.clear_cnt = clr;
        @(posedge clk);
        #1;
        if (valid) vidx++;
        if (bus.err_pulse) pulses++;
        if (bus.state == 2'd2) saw_locked = 1'b1;
        bus.din_valid = 1'b0;
        bus.clear_cnt = 1'b0;
    endtask

    task automatic good(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int cyc;
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;

        // Test 1: reset values, lock on valid bit 95, clean long run.
        do_reset();
        check("t1_rst_locked", 32'(bus.locked), 0);
        check("t1_rst_state", 32'(bus.state), 0);
        check("t1_rst_err_count", 32'(bus.err_count), 0);
        check("t1_rst_err_pulse", 32'(bus.err_pulse), 0);
        check("t1_rst_lol", 32'(bus.lol_sticky), 0);
        good(31);
        check("t1_sync_after_fill", 32'(bus.state), 1);
        good(63);
        check("t1_locked_bit94", 32'(bus.locked), 0);
        good(1);
        check("t1_locked_bit95", 32'(bus.locked), 1);
        check("t1_state_bit95", 32'(bus.state), 2);
        good(10000 - 95);
        check("t1_err_count_10k", 32'(bus.err_count), 0);
        check("t1_pulses_10k", 32'(pulses), 0);
        check("t1_still_locked", 32'(bus.locked), 1);

        // Test 2: single flipped bit at index 500.
        do_reset();
        good(499);
        step(1'b1, 1'b1, 1'b0);
        check("t2_pulse_on_err", 32'(bus.err_pulse), 1);
        good(1);
        check("t2_pulse_one_cycle", 32'(bus.err_pulse), 0);
        good(200);
        check("t2_pulses", 32'(pulses), 1);
        check("t2_err_count", 32'(bus.err_count), 1);
        check("t2_locked", 32'(bus.locked), 1);

        // Test 3: 16 errors in one window -> loss of lock, relock, clear.
        do_reset();
        good(95);
        for (int k = 0; k < 15; k++) begin
            if (k > 0) good(9);
            step(1'b1, 1'b1, 1'b0);
        end
        check("t3_locked_15err", 32'(bus.locked), 1);
        good(9);
        step(1'b1, 1'b1, 1'b0);                 // valid bit 246, 16th error
        check("t3_vidx", 32'(vidx), 246);
        check("t3_lol_locked", 32'(bus.locked), 0);
        check("t3_lol_state", 32'(bus.state), 0);
        check("t3_lol_sticky", 32'(bus.lol_sticky), 1);
        check("t3_err_count", 32'(bus.err_count), 16);
        check("t3_pulses", 32'(pulses), 16);
        good(94);
        check("t3_relock_minus1", 32'(bus.locked), 0);
        good(1);
        check("t3_relock", 32'(bus.locked), 1);
        check("t3_sticky_held", 32'(bus.lol_sticky), 1);
        step(1'b1, 1'b0, 1'b1);
        check("t3_clear_count", 32'(bus.err_count), 0);
        check("t3_clear_sticky", 32'(bus.lol_sticky), 0);
        check("t3_clear_keeps_lock", 32'(bus.locked), 1);

        // Window boundary: 15+15 split over two windows holds lock;
        // the last bit of a window counts toward that window's threshold.
        do_reset();
        good(1104);
        repeat (30) step(1'b1, 1'b1, 1'b0);     // bits 1105..1134
        check("tw_split_locked", 32'(bus.locked), 1);
        check("tw_split_count", 32'(bus.err_count), 30);
        good(3151 - 1134);
        repeat (15) step(1'b1, 1'b1, 1'b0);     // bits 3152..3166
        check("tw_15_locked", 32'(bus.locked), 1);
        step(1'b1, 1'b1, 1'b0);                 // bit 3167, win_cnt = 1023
        check("tw_vidx", 32'(vidx), 3167);
        check("tw_last_bit_lol", 32'(bus.locked), 0);
        check("tw_last_bit_sticky", 32'(bus.lol_sticky), 1);
        check("tw_count", 32'(bus.err_count), 46);

        // Test 4: all-zero stream never locks.
        do_reset();
        zero_mode = 1'b1;
        good(600);
        check("t4_never_locked", 32'(saw_locked), 0);
        check("t4_locked", 32'(bus.locked), 0);
        check("t4_state_sync", 32'(bus.state), 1);
        check("t4_err_count", 32'(bus.err_count), 0);

        // Test 5: din_valid at about 50%, idle cycles with garbage din.
        do_reset();
        cyc = 0;
        while (vidx < 94 && cyc < 5000) begin
            step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            cyc++;
        end
        check("t5_reach_94", 32'(vidx), 94);
        check("t5_locked_94", 32'(bus.locked), 0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        check("t5_idle_locked", 32'(bus.locked), 0);
        check("t5_idle_state", 32'(bus.state), 1);
        step(1'b1, 1'b0, 1'b0);
        check("t5_locked_95", 32'(bus.locked), 1);
        repeat (400) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check("t5_err_count", 32'(bus.err_count), 0);
        check("t5_pulses", 32'(pulses), 0);
        check("t5_still_locked", 32'(bus.locked), 1);

        // Test 6: clear on an errored bit, then asynchronous reset mid-lock.
        do_reset();
        good(95);
        step(1'b1, 1'b1, 1'b0);
        check("t6_first_err", 32'(bus.err_count), 1);
        step(1'b1, 1'b1, 1'b1);
        check("t6_clear_on_err", 32'(bus.err_count), 1);
        check("t6_clear_on_err_pulse", 32'(bus.err_pulse), 1);
        step(1'b1, 1'b0, 1'b1);
        check("t6_clear_clean", 32'(bus.err_count), 0);
        step(1'b1, 1'b1, 1'b0);
        check("t6_pre_rst_count", 32'(bus.err_count), 1);
        rst_n = 1'b1;
        #1;
        check("t6_rst_locked", 32'(bus.locked), 0);
        check("t6_rst_pulse", 32'(bus.err_pulse), 0);
        check("t6_rst_count", 32'(bus.err_count), 0);
        check("t6_rst_sticky", 32'(bus.lol_sticky), 0);
        check("t6_rst_state", 32'(bus.state), 0);
        rst_n = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
